// File: rtl/boot_pkg.sv
// Shared loader state encoding and byte-stream framing constants.
// No logic; pure declarations.
package boot_pkg;

    typedef enum logic [2:0] {
        LEN,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } boot_state_t;

    localparam int LEN_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word shifter for the length header and the payload.
// word_vld is combinational on the 4th accepted byte; stalls simply hold the partial word.
module word_assembler
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [7:0]  byte_dat,
    input  logic        byte_en,
    output logic [31:0] word_dat,
    output logic        word_vld
);

    logic [23:0] shreg;
    logic [1:0]  cnt;

    // The completed word is exposed in the cycle of its last byte so the
    // parent can register the imem write for the very next cycle.
    assign word_vld = byte_en && (cnt == 2'(BYTES_PER_WORD - 1));
    assign word_dat = {byte_dat, shreg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (clr) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (byte_en) begin
            shreg <= {byte_dat, shreg[23:8]};
            cnt   <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed image into instruction memory and releases the core.
// Writes land one cycle after a word's 4th byte; ready drops only in DONE/ERROR.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int XLEN   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      byte_data_i,
    input  logic            byte_valid_i,
    output logic            byte_ready_o,
    input  logic            reload_i,
    output logic            imem_we_o,
    output logic [31:0]     imem_addr_o,
    output logic [XLEN-1:0] imem_wdata_o,
    output logic            core_hold_o,
    output logic            done_o,
    output logic            error_o
);

    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    boot_state_t     state;
    logic [ADDR_W:0] word_idx;
    logic [ADDR_W:0] word_cnt;
    logic [7:0]      csum;
    logic            accept;
    logic            asm_en;
    logic            reload_hit;
    logic [31:0]     word_dat;
    logic            word_vld;

    assign accept     = byte_valid_i && byte_ready_o;
    assign asm_en     = accept && (state == LEN || state == LOAD);
    assign reload_hit = reload_i && (state == DONE || state == ERROR);

    word_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .clr      (reload_hit),
        .byte_dat (byte_data_i),
        .byte_en  (asm_en),
        .word_dat (word_dat),
        .word_vld (word_vld)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= LEN;
            word_idx     <= '0;
            word_cnt     <= '0;
            csum         <= '0;
            byte_ready_o <= 1'b1;
            imem_we_o    <= 1'b0;
            imem_addr_o  <= '0;
            imem_wdata_o <= '0;
            core_hold_o  <= 1'b1;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
        end else begin
            imem_we_o <= 1'b0;
            case (state)
                LEN: begin
                    if (word_vld) begin
                        word_cnt <= word_dat[ADDR_W:0];
                        if (word_dat > MAX_WORDS) begin
                            state        <= ERROR;
                            error_o      <= 1'b1;
                            byte_ready_o <= 1'b0;
                        end else if (word_dat == 32'd0) begin
                            state <= CHECK;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        csum <= csum ^ byte_data_i;
                    end
                    if (word_vld) begin
                        imem_we_o    <= 1'b1;
                        imem_addr_o  <= 32'({word_idx, 2'b00});
                        imem_wdata_o <= XLEN'(word_dat);
                        word_idx     <= word_idx + 1'b1;
                        if (word_idx + 1'b1 == word_cnt) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        byte_ready_o <= 1'b0;
                        if (byte_data_i == csum) begin
                            state       <= DONE;
                            done_o      <= 1'b1;
                            core_hold_o <= 1'b0;
                        end else begin
                            state   <= ERROR;
                            error_o <= 1'b1;
                        end
                    end
                end
                DONE, ERROR: begin
                    if (reload_hit) begin
                        state        <= LEN;
                        word_idx     <= '0;
                        word_cnt     <= '0;
                        csum         <= '0;
                        byte_ready_o <= 1'b1;
                        core_hold_o  <= 1'b1;
                        done_o       <= 1'b0;
                        error_o      <= 1'b0;
                    end
                end
                default: begin
                    state <= ERROR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: nominal, checksum error, zero/overflow length,
// stalls with reload, and mid-load reset.
module tb_imem_boot_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        reload;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        done;
    logic        error;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;

    imem_boot_loader #(.ADDR_W(10), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_data_i  (byte_data),
        .byte_valid_i (byte_valid),
        .byte_ready_o (byte_ready),
        .reload_i     (reload),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_wdata_o (imem_wdata),
        .core_hold_o  (core_hold),
        .done_o       (done),
        .error_o      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) wr_cnt++;
    end

    task automatic do_reset();
        rst        = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        reload     = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_stall);
        int stall;
        int waited;
        stall = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
        for (int i = 0; i < stall; i++) begin
            byte_valid = 1'b0;
            byte_data  = 8'hA5;
            @(posedge clk); #1;
        end
        byte_data  = b;
        byte_valid = 1'b1;
        waited     = 0;
        while (byte_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (waited >= 20) begin
            failures++;
            $display("FAIL ready_timeout byte=%02h ready=%b required=1", b, byte_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input int max_stall);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], max_stall);
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== addr || imem_wdata !== w) begin
            failures++;
            $display("FAIL imem_write we=%b addr=%h wdata=%h required we=1 addr=%h wdata=%h",
                     imem_we, imem_addr, imem_wdata, addr, w);
        end
    endtask

    task automatic send_nominal(input int max_stall, input logic [7:0] csum_byte);
        send_byte(8'h02, max_stall);
        send_byte(8'h00, max_stall);
        send_byte(8'h00, max_stall);
        send_byte(8'h00, max_stall);
        checks++;
        if (imem_we !== 1'b0) begin
            failures++;
            $display("FAIL header_no_write we=%b required 0", imem_we);
        end
        send_word(32'h00500093, 32'h0, max_stall);
        send_word(32'h00108133, 32'h4, max_stall);
        send_byte(csum_byte, max_stall);
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({byte_ready, imem_we, core_hold, done, error} !== 5'b10100 ||
            imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_state rdy/we/hold/done/err=%b addr=%h wdata=%h required 10100 0 0",
                     {byte_ready, imem_we, core_hold, done, error}, imem_addr, imem_wdata);
        end
    endtask

    task automatic test_nominal();
        int w0;
        do_reset();
        w0 = wr_cnt;
        send_nominal(0, 8'h61);
        checks++;
        if (done !== 1'b1 || core_hold !== 1'b0 || error !== 1'b0 || byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL nominal_done done=%b hold=%b err=%b rdy=%b required 1 0 0 0",
                     done, core_hold, error, byte_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (imem_we !== 1'b0 || imem_addr !== 32'h4 || imem_wdata !== 32'h00108133) begin
            failures++;
            $display("FAIL nominal_hold we=%b addr=%h wdata=%h required 0 4 00108133",
                     imem_we, imem_addr, imem_wdata);
        end
        checks++;
        if (wr_cnt - w0 !== 2) begin
            failures++;
            $display("FAIL nominal_write_count got=%0d required=2", wr_cnt - w0);
        end
    endtask

    task automatic test_bad_checksum();
        int w0;
        do_reset();
        w0 = wr_cnt;
        send_nominal(0, 8'h62);
        checks++;
        if (error !== 1'b1 || core_hold !== 1'b1 || byte_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL bad_csum err=%b hold=%b rdy=%b done=%b required 1 1 0 0",
                     error, core_hold, byte_ready, done);
        end
        byte_valid = 1'b1;
        byte_data  = 8'h11;
        repeat (5) @(posedge clk);
        #1 byte_valid = 1'b0;
        checks++;
        if (wr_cnt - w0 !== 2 || error !== 1'b1) begin
            failures++;
            $display("FAIL bad_csum_quiet writes=%0d err=%b required 2 1", wr_cnt - w0, error);
        end
    endtask

    task automatic test_zero_length();
        int w0;
        do_reset();
        w0 = wr_cnt;
        for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
        checks++;
        if (byte_ready !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_check_state rdy=%b done=%b err=%b required 1 0 0",
                     byte_ready, done, error);
        end
        send_byte(8'h00, 0);
        byte_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || core_hold !== 1'b0 || wr_cnt - w0 !== 0) begin
            failures++;
            $display("FAIL zero_len_done done=%b hold=%b writes=%0d required 1 0 0",
                     done, core_hold, wr_cnt - w0);
        end
    endtask

    task automatic test_overflow();
        int w0;
        do_reset();
        w0 = wr_cnt;
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        byte_valid = 1'b0;
        checks++;
        if (error !== 1'b1 || byte_ready !== 1'b0 || core_hold !== 1'b1 || wr_cnt - w0 !== 0) begin
            failures++;
            $display("FAIL overflow_1025 err=%b rdy=%b hold=%b writes=%0d required 1 0 1 0",
                     error, byte_ready, core_hold, wr_cnt - w0);
        end
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        byte_valid = 1'b0;
        checks++;
        if (error !== 1'b0 || byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL max_len_1024 err=%b rdy=%b required 0 1", error, byte_ready);
        end
    endtask

    task automatic test_stall_reload();
        int w0;
        do_reset();
        w0 = wr_cnt;
        send_nominal(3, 8'h61);
        checks++;
        if (done !== 1'b1 || core_hold !== 1'b0 || wr_cnt - w0 !== 2) begin
            failures++;
            $display("FAIL stall_done done=%b hold=%b writes=%0d required 1 0 2",
                     done, core_hold, wr_cnt - w0);
        end
        // Byte offered alongside reload must be dropped (ready is low that cycle).
        reload     = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        @(posedge clk); #1;
        reload     = 1'b0;
        byte_valid = 1'b0;
        checks++;
        if (core_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL reload_state hold=%b done=%b err=%b rdy=%b required 1 0 0 1",
                     core_hold, done, error, byte_ready);
        end
        send_byte(8'h01, 1);
        send_byte(8'h00, 1);
        send_byte(8'h00, 1);
        send_byte(8'h00, 1);
        send_word(32'hDEADBEEF, 32'h0, 1);
        send_byte(8'h22, 1);
        byte_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || core_hold !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL reload_second_image done=%b hold=%b err=%b required 1 0 0",
                     done, core_hold, error);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        #2 rst = 1'b0;
        byte_valid = 1'b0;
        #1;
        checks++;
        if ({byte_ready, imem_we, core_hold, done, error} !== 5'b10100 ||
            imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset rdy/we/hold/done/err=%b addr=%h wdata=%h required 10100 0 0",
                     {byte_ready, imem_we, core_hold, done, error}, imem_addr, imem_wdata);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        send_nominal(0, 8'h61);
        checks++;
        if (done !== 1'b1 || core_hold !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_reload done=%b hold=%b err=%b required 1 0 0",
                     done, core_hold, error);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_zero_length();
        test_overflow();
        test_stall_reload();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder of the single-cycle RV32 core's instruction memory.
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver, and assembles little-endian 32-bit words.
- Writes each word to instruction memory.
- Holds the core in reset until a complete, checksum-verified image is loaded, then releases it so execution starts at PC 0.

Parameters:
- ADDR_W, 10, instruction-memory depth in words = 2**ADDR_W; maximum image length.
- XLEN, 32, instruction word width; fixed for RV32.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- byte_data_i  input  8  incoming stream byte.
- byte_valid_i  input  1  byte_data_i is valid.
- byte_ready_o  output  1  loader can accept a byte this cycle.
- reload_i  input  1  single-cycle pulse; restarts loading from DONE or ERROR.
- imem_we_o  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr_o  output  32  byte address of the word written (word index × 4).
- imem_wdata_o  output  32  word written.
- core_hold_o  output  1  1 = hold core in reset; 0 = core runs.
- done_o  output  1  image loaded and checksum matched.
- error_o  output  1  length overflow or checksum mismatch.

Behaviour:
- Reset (rst low, asynchronous):
  - State = LEN; byte/word counters = 0; checksum accumulator = 0.
  - Outputs: byte_ready_o = 1, imem_we_o = 0, imem_addr_o = 0, imem_wdata_o = 0, core_hold_o = 1, done_o = 0, error_o = 0.
- Handshake:
  - A byte transfers only in a cycle where byte_valid_i && byte_ready_o.
  - byte_ready_o = 1 in LEN, LOAD and CHECK; 0 in DONE and ERROR.
  - Stalls (valid low) of any length are legal. Data is ignored when valid is low.
- State LEN:
  - Collect 4 bytes, little-endian, into the 32-bit word count N.
  - On the 4th byte:
    - N > 2**ADDR_W → ERROR.
    - N == 0 → CHECK.
    - Otherwise → LOAD.
- State LOAD:
  - Collect 4 bytes per word, little-endian; the first byte is bits [7:0].
  - Every payload byte is XORed into the 8-bit checksum accumulator.
  - Write timing: in the cycle after the 4th byte of word k is accepted, imem_we_o = 1 for exactly one cycle, with imem_addr_o = 4k and imem_wdata_o = the assembled word.
  - Acceptance of the next byte continues in that same cycle, with no bubble.
  - After word N-1 is accepted → CHECK.
- State CHECK:
  - Accept one byte.
  - Byte equals the accumulator → DONE; otherwise → ERROR.
- State DONE: done_o = 1 and core_hold_o = 0, registered; both change the cycle after the checksum byte is accepted.
- State ERROR: error_o = 1 and core_hold_o = 1.
- reload_i:
  - Acts only in DONE or ERROR. Next cycle: state = LEN, counters and accumulator cleared, done_o = error_o = 0, core_hold_o = 1.
  - Ignored in all other states.
- imem_addr_o and imem_wdata_o hold their last value when imem_we_o = 0.
- Reset mid-load: everything returns to reset values immediately. Words already written stay in memory; the core remains held.
- Simultaneous events:
  - reload_i in DONE together with byte_valid_i: the byte is not accepted, because ready is 0 that cycle.
  - The final checksum byte and a pending imem write can overlap in the same cycle; both complete.
- Width rules:
  - The word counter is ADDR_W+1 bits so that N == 2**ADDR_W is representable.
  - imem_addr_o = {word_idx, 2'b00}, zero-extended to 32 bits.

Decomposition:
- Package boot_pkg holds:
  - State enum: LEN, LOAD, CHECK, DONE, ERROR.
  - Constant LEN_BYTES = 4.
  - Constant BYTES_PER_WORD = 4.
- Sub-module word_assembler: shift-in of 4 bytes with a 2-bit byte counter and a word_valid pulse. It is reused for both the length header and the payload.
- The FSM, word counter, checksum and output registers live in imem_boot_loader.

Test Plan:
- Nominal load:
  - Stimulus: bytes 02 00 00 00, 93 00 50 00, 33 81 10 00, 61, with valid held high.
  - Response: imem writes (0x0, 0x00500093) then (0x4, 0x00108133), each one cycle after its 4th byte; done_o = 1 and core_hold_o = 0 one cycle after byte 61.
- Bad checksum: same stream with final byte 62 → error_o = 1, core_hold_o = 1, byte_ready_o = 0; no further writes.
- Zero length: bytes 00 00 00 00, 00 → no imem_we_o pulses; done_o = 1.
- Overflow: with ADDR_W = 10, length bytes 01 04 00 00 (N = 1025) → ERROR on the 4th byte; no writes.
- Stalls and reload:
  - Stimulus: nominal stream with byte_valid_i toggled randomly.
  - Response: identical writes and done_o.
  - Then pulse reload_i → core_hold_o = 1, state LEN; a second image loads correctly.
- Mid-load reset: assert rst low after the 6th byte → all outputs at reset values immediately; a fresh full stream then loads successfully.
